// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a per-register busy bit
// (scoreboard) for tracking pending writes.
// Register 0 is hardwired to zero and is never busy.
// Optional feature: define REGFILE_SB_BYPASS_EN to forward same-cycle write
// data and busy-clear to the read ports and to the reservation stall check.
module regfile_sb #(
  parameter int N  = 16,
  parameter int R  = 3,
  parameter int NR = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [R-1:0]    wa,
  input  logic [N-1:0]    wd,
  input  logic [NR*R-1:0] ra,
  output logic [NR*N-1:0] rd,
  output logic [NR-1:0]   rd_busy,
  input  logic            rsv_en,
  input  logic [R-1:0]    rsv_addr,
  output logic            rsv_stall
);

  localparam int DEPTH = 1 << R;

  logic [N-1:0]     regs_r [DEPTH];
  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;
  logic             wr_s;
  logic             rsv_acc_s;

  // Write and reservation qualification; register 0 ignores both.
  always_comb begin
    wr_s = we && (wa != '0);
`ifdef REGFILE_SB_BYPASS_EN
    // A write to the same register this cycle frees it, so do not stall.
    rsv_stall = rsv_en && (rsv_addr != '0) && busy_r[rsv_addr] &&
                !(we && (wa == rsv_addr));
`else
    rsv_stall = rsv_en && (rsv_addr != '0) && busy_r[rsv_addr];
`endif
    rsv_acc_s = rsv_en && (rsv_addr != '0) && !rsv_stall;
  end

  // Next busy state: an accepted reservation beats a same-cycle write clear.
  always_comb begin
    busy_nxt_s = '0;
    for (int j = 1; j < DEPTH; j++) begin
      if (rsv_acc_s && (rsv_addr == R'(j))) begin
        busy_nxt_s[j] = 1'b1;
      end else if (wr_s && (wa == R'(j))) begin
        busy_nxt_s[j] = 1'b0;
      end else begin
        busy_nxt_s[j] = busy_r[j];
      end
    end
  end

  // Register storage; register 0 is only ever loaded with zero by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_r[k] <= '0;
      end
    end else if (wr_s) begin
      regs_r[wa] <= wd;
    end
  end

  // Busy-bit storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Combinational read ports with zero register and optional forwarding.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < NR; i++) begin
      if (ra[i*R +: R] == '0) begin
        rd[i*N +: N] = '0;
        rd_busy[i]   = 1'b0;
      end
`ifdef REGFILE_SB_BYPASS_EN
      // Forwarding is suppressed while reset holds the file at zero.
      else if (wr_s && !reset && (wa == ra[i*R +: R])) begin
        rd[i*N +: N] = wd;
        rd_busy[i]   = 1'b0;
      end
`endif
      else begin
        rd[i*N +: N] = regs_r[ra[i*R +: R]];
        rd_busy[i]   = busy_r[ra[i*R +: R]];
      end
    end
  end

endmodule
